// File: rtl/decode_exec_writeback_if.sv
// Bundle of decode, ALU and write-back signals for the RV32I decode/execute/write-back slice.
// The slave modport is the slice itself; the master side drives instructions, operands and write-back requests.
interface decode_exec_writeback_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
);
  // Decoder
  logic [31:0]         inst_i;
  logic [4:0]          rd_o;
  logic [4:0]          rs1_o;
  logic [4:0]          rs2_o;
  logic [XLEN-1:0]     imm_o;
  logic                sig_mem_we_o;
  logic                sig_wb_we_o;
  logic [1:0]          sig_wb_src_o;
  logic                sig_alu_src2_o;
  logic [3:0]          sig_alu_op_o;
  logic                sig_ebreak_o;
  logic                sig_illegal_o;
  // ALU
  logic [XLEN-1:0]     alu_rs1_i;
  logic [XLEN-1:0]     alu_rs2_i;
  logic [XLEN-1:0]     alu_imm_i;
  logic                alu_sig_src2_i;
  logic [3:0]          alu_sig_op_i;
  logic [XLEN-1:0]     res_o;
  // Write-back and register file
  logic                wb_we_i;
  logic [4:0]          wb_rd_i;
  logic [XLEN-1:0]     wb_res_alu_i;
  logic [XLEN-1:0]     wb_res_mem_i;
  logic [XLEN-1:0]     wb_res_pc_i;
  logic [1:0]          wb_sig_src_i;
  logic [XLEN*NREGS-1:0] gpr_o;

  modport slave (
    input  inst_i, alu_rs1_i, alu_rs2_i, alu_imm_i, alu_sig_src2_i, alu_sig_op_i,
           wb_we_i, wb_rd_i, wb_res_alu_i, wb_res_mem_i, wb_res_pc_i, wb_sig_src_i,
    output rd_o, rs1_o, rs2_o, imm_o, sig_mem_we_o, sig_wb_we_o, sig_wb_src_o,
           sig_alu_src2_o, sig_alu_op_o, sig_ebreak_o, sig_illegal_o, res_o, gpr_o
  );

  modport master (
    output inst_i, alu_rs1_i, alu_rs2_i, alu_imm_i, alu_sig_src2_i, alu_sig_op_i,
           wb_we_i, wb_rd_i, wb_res_alu_i, wb_res_mem_i, wb_res_pc_i, wb_sig_src_i,
    input  rd_o, rs1_o, rs2_o, imm_o, sig_mem_we_o, sig_wb_we_o, sig_wb_src_o,
           sig_alu_src2_o, sig_alu_op_o, sig_ebreak_o, sig_illegal_o, res_o, gpr_o
  );
endinterface

// File: rtl/decode_exec_writeback.sv
// RV32I decode/execute/write-back slice: combinational decoder and ALU, plus the
// 31x32 register file written at write-back (x0 hard-wired to zero).
module decode_exec_writeback #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input logic                  clk_i,
  input logic                  rst_ni,
  decode_exec_writeback_if.slave bus
);
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [3:0] ALU_ADD = 4'd0,  ALU_SUB = 4'd1,  ALU_SLL = 4'd2,  ALU_SLT = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4, ALU_XOR = 4'd5,  ALU_SRL = 4'd6,  ALU_SRA = 4'd7;
  localparam logic [3:0] ALU_OR = 4'd8,   ALU_AND = 4'd9,  ALU_EQ = 4'd10,  ALU_NE = 4'd11;
  localparam logic [3:0] ALU_LT = 4'd12,  ALU_GE = 4'd13,  ALU_LTU = 4'd14, ALU_GEU = 4'd15;

  localparam logic [1:0] WB_ALU = 2'd0, WB_MEM = 2'd1, WB_PC = 2'd2;

  // funct3 to ALU op for OP/OP-IMM; alt selects SUB or SRA
  function automatic logic [3:0] arith_op(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  arith_op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  arith_op = ALU_SLL;
      3'b010:  arith_op = ALU_SLT;
      3'b011:  arith_op = ALU_SLTU;
      3'b100:  arith_op = ALU_XOR;
      3'b101:  arith_op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  arith_op = ALU_OR;
      default: arith_op = ALU_AND;
    endcase
  endfunction

  logic [6:0]      opcode_s;
  logic [2:0]      funct3_s;
  logic [31:0]     imm_i_s, imm_s_s, imm_b_s, imm_u_s, imm_j_s;
  logic [XLEN-1:0] op2_s;
  logic [4:0]      shamt_s;
  logic [XLEN-1:0] wb_data_d;
  logic [XLEN-1:0] regs_q [1:NREGS-1];

  assign opcode_s = bus.inst_i[6:0];
  assign funct3_s = bus.inst_i[14:12];
  assign imm_i_s  = {{20{bus.inst_i[31]}}, bus.inst_i[31:20]};
  assign imm_s_s  = {{20{bus.inst_i[31]}}, bus.inst_i[31:25], bus.inst_i[11:7]};
  assign imm_b_s  = {{20{bus.inst_i[31]}}, bus.inst_i[7], bus.inst_i[30:25], bus.inst_i[11:8], 1'b0};
  assign imm_u_s  = {bus.inst_i[31:12], 12'b0};
  assign imm_j_s  = {{12{bus.inst_i[31]}}, bus.inst_i[19:12], bus.inst_i[20], bus.inst_i[30:21], 1'b0};

  // Instruction decoder
  always_comb begin
    bus.rd_o           = bus.inst_i[11:7];
    bus.rs1_o          = bus.inst_i[19:15];
    bus.rs2_o          = bus.inst_i[24:20];
    bus.imm_o          = imm_i_s;
    bus.sig_mem_we_o   = 1'b0;
    bus.sig_wb_we_o    = 1'b0;
    bus.sig_wb_src_o   = WB_ALU;
    bus.sig_alu_src2_o = 1'b0;
    bus.sig_alu_op_o   = ALU_ADD;
    bus.sig_ebreak_o   = 1'b0;
    bus.sig_illegal_o  = 1'b0;
    case (opcode_s)
      OPC_OP: begin
        bus.sig_alu_op_o = arith_op(funct3_s, bus.inst_i[30]);
        bus.sig_wb_we_o  = 1'b1;
      end
      OPC_OPIMM: begin
        bus.sig_alu_op_o   = arith_op(funct3_s, (funct3_s == 3'b101) && bus.inst_i[30]);
        bus.sig_alu_src2_o = 1'b1;
        bus.sig_wb_we_o    = 1'b1;
      end
      OPC_LUI: begin
        bus.rs1_o          = 5'd0;
        bus.imm_o          = imm_u_s;
        bus.sig_alu_src2_o = 1'b1;
        bus.sig_wb_we_o    = 1'b1;
      end
      OPC_LOAD: begin
        bus.sig_alu_src2_o = 1'b1;
        bus.sig_wb_we_o    = 1'b1;
        bus.sig_wb_src_o   = WB_MEM;
      end
      OPC_STORE: begin
        bus.imm_o          = imm_s_s;
        bus.sig_alu_src2_o = 1'b1;
        bus.sig_mem_we_o   = 1'b1;
      end
      OPC_BRANCH: begin
        bus.imm_o = imm_b_s;
        case (funct3_s)
          3'b000:  bus.sig_alu_op_o = ALU_EQ;
          3'b001:  bus.sig_alu_op_o = ALU_NE;
          3'b100:  bus.sig_alu_op_o = ALU_LT;
          3'b101:  bus.sig_alu_op_o = ALU_GE;
          3'b110:  bus.sig_alu_op_o = ALU_LTU;
          3'b111:  bus.sig_alu_op_o = ALU_GEU;
          default: bus.sig_illegal_o = 1'b1;
        endcase
      end
      OPC_JAL: begin
        bus.imm_o        = imm_j_s;
        bus.sig_wb_we_o  = 1'b1;
        bus.sig_wb_src_o = WB_PC;
      end
      OPC_JALR: begin
        bus.sig_alu_src2_o = 1'b1;
        bus.sig_wb_we_o    = 1'b1;
        bus.sig_wb_src_o   = WB_PC;
      end
      OPC_SYSTEM: begin
        if (bus.inst_i == 32'h0010_0073) begin
          bus.sig_ebreak_o = 1'b1;
        end else begin
          bus.sig_illegal_o = 1'b1;
        end
      end
      default: bus.sig_illegal_o = 1'b1;
    endcase
  end

  assign op2_s   = bus.alu_sig_src2_i ? bus.alu_imm_i : bus.alu_rs2_i;
  assign shamt_s = op2_s[4:0];

  // ALU; compare ops return the branch-taken flag in bit 0
  always_comb begin
    case (bus.alu_sig_op_i)
      ALU_ADD:  bus.res_o = bus.alu_rs1_i + op2_s;
      ALU_SUB:  bus.res_o = bus.alu_rs1_i - op2_s;
      ALU_SLL:  bus.res_o = bus.alu_rs1_i << shamt_s;
      ALU_SLT:  bus.res_o = {31'd0, $signed(bus.alu_rs1_i) < $signed(op2_s)};
      ALU_SLTU: bus.res_o = {31'd0, bus.alu_rs1_i < op2_s};
      ALU_XOR:  bus.res_o = bus.alu_rs1_i ^ op2_s;
      ALU_SRL:  bus.res_o = bus.alu_rs1_i >> shamt_s;
      ALU_SRA:  bus.res_o = $signed(bus.alu_rs1_i) >>> shamt_s;
      ALU_OR:   bus.res_o = bus.alu_rs1_i | op2_s;
      ALU_AND:  bus.res_o = bus.alu_rs1_i & op2_s;
      ALU_EQ:   bus.res_o = {31'd0, bus.alu_rs1_i == op2_s};
      ALU_NE:   bus.res_o = {31'd0, bus.alu_rs1_i != op2_s};
      ALU_LT:   bus.res_o = {31'd0, $signed(bus.alu_rs1_i) < $signed(op2_s)};
      ALU_GE:   bus.res_o = {31'd0, $signed(bus.alu_rs1_i) >= $signed(op2_s)};
      ALU_LTU:  bus.res_o = {31'd0, bus.alu_rs1_i < op2_s};
      ALU_GEU:  bus.res_o = {31'd0, bus.alu_rs1_i >= op2_s};
      default:  bus.res_o = {XLEN{1'b0}};
    endcase
  end

  // Write-back data select; the unused encoding falls back to the ALU result
  always_comb begin
    case (bus.wb_sig_src_i)
      WB_ALU:  wb_data_d = bus.wb_res_alu_i;
      WB_MEM:  wb_data_d = bus.wb_res_mem_i;
      WB_PC:   wb_data_d = bus.wb_res_pc_i + 32'd4;
      default: wb_data_d = bus.wb_res_alu_i;
    endcase
  end

  // Register file x1..x31
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 1; i < NREGS; i++) begin
        regs_q[i] <= {XLEN{1'b0}};
      end
    end else if (bus.wb_we_i && (bus.wb_rd_i != 5'd0)) begin
      regs_q[bus.wb_rd_i] <= wb_data_d;
    end
  end

  // Flattened register view with x0 tied to zero
  always_comb begin
    bus.gpr_o[XLEN-1:0] = {XLEN{1'b0}};
    for (int i = 1; i < NREGS; i++) begin
      bus.gpr_o[i*XLEN +: XLEN] = regs_q[i];
    end
  end
endmodule

// File: tb/tb_decode_exec_writeback.sv
// Directed, table-driven bench for decode_exec_writeback: decoder and ALU vector
// tables followed by hand-written register-file sequences around reset.
module tb_decode_exec_writeback;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  decode_exec_writeback_if #(.XLEN(32), .NREGS(32)) dif ();
  decode_exec_writeback #(.XLEN(32), .NREGS(32)) dut (.clk_i(clk), .rst_ni(rst_n), .bus(dif.slave));

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic        full;
    logic        alu;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        mem_we;
    logic        wb_we;
    logic [1:0]  wb_src;
    logic        src2;
    logic [3:0]  op;
    logic        ebreak;
    logic        illegal;
  } dec_vec_t;

  typedef struct {
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] imm;
    logic        src2;
    logic [3:0]  op;
    logic [31:0] res;
  } alu_vec_t;

  dec_vec_t dv [14];
  alu_vec_t av [18];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] word(input int i);
    return dif.gpr_o[i*32 +: 32];
  endfunction

  task automatic wb_cycle(input logic we, input logic [4:0] rd, input logic [1:0] src,
                          input logic [31:0] a, input logic [31:0] m, input logic [31:0] p);
    @(negedge clk);
    dif.wb_we_i = we; dif.wb_rd_i = rd; dif.wb_sig_src_i = src;
    dif.wb_res_alu_i = a; dif.wb_res_mem_i = m; dif.wb_res_pc_i = p;
    @(negedge clk);
    dif.wb_we_i = 1'b0;
  endtask

  initial begin
    //          inst          full  alu   rd     rs1    rs2    imm            mem   wb    src   s2    op     eb    il
    dv[0]  = '{32'h00500093, 1'b1, 1'b1, 5'd1,  5'd0,  5'd5,  32'h00000005, 1'b0, 1'b1, 2'd0, 1'b1, 4'd0,  1'b0, 1'b0};
    dv[1]  = '{32'h40208133, 1'b1, 1'b1, 5'd2,  5'd1,  5'd2,  32'h00000402, 1'b0, 1'b1, 2'd0, 1'b0, 4'd1,  1'b0, 1'b0};
    dv[2]  = '{32'h4051D193, 1'b1, 1'b1, 5'd3,  5'd3,  5'd5,  32'h00000405, 1'b0, 1'b1, 2'd0, 1'b1, 4'd7,  1'b0, 1'b0};
    dv[3]  = '{32'h123450B7, 1'b1, 1'b1, 5'd1,  5'd0,  5'd3,  32'h12345000, 1'b0, 1'b1, 2'd0, 1'b1, 4'd0,  1'b0, 1'b0};
    dv[4]  = '{32'h0081A283, 1'b1, 1'b1, 5'd5,  5'd3,  5'd8,  32'h00000008, 1'b0, 1'b1, 2'd1, 1'b1, 4'd0,  1'b0, 1'b0};
    dv[5]  = '{32'h00112223, 1'b1, 1'b1, 5'd4,  5'd2,  5'd1,  32'h00000004, 1'b1, 1'b0, 2'd0, 1'b1, 4'd0,  1'b0, 1'b0};
    dv[6]  = '{32'hFE209EE3, 1'b1, 1'b1, 5'd29, 5'd1,  5'd2,  32'hFFFFFFFC, 1'b0, 1'b0, 2'd0, 1'b0, 4'd11, 1'b0, 1'b0};
    dv[7]  = '{32'h008000EF, 1'b1, 1'b0, 5'd1,  5'd0,  5'd8,  32'h00000008, 1'b0, 1'b1, 2'd2, 1'b0, 4'd0,  1'b0, 1'b0};
    dv[8]  = '{32'h00008067, 1'b1, 1'b1, 5'd0,  5'd1,  5'd0,  32'h00000000, 1'b0, 1'b1, 2'd2, 1'b1, 4'd0,  1'b0, 1'b0};
    dv[9]  = '{32'h0020F463, 1'b1, 1'b1, 5'd8,  5'd1,  5'd2,  32'h00000008, 1'b0, 1'b0, 2'd0, 1'b0, 4'd15, 1'b0, 1'b0};
    dv[10] = '{32'hFFF08093, 1'b1, 1'b1, 5'd1,  5'd1,  5'd31, 32'hFFFFFFFF, 1'b0, 1'b1, 2'd0, 1'b1, 4'd0,  1'b0, 1'b0};
    dv[11] = '{32'h00100073, 1'b0, 1'b0, 5'd0,  5'd0,  5'd0,  32'h00000000, 1'b0, 1'b0, 2'd0, 1'b0, 4'd0,  1'b1, 1'b0};
    dv[12] = '{32'h0000000B, 1'b0, 1'b0, 5'd0,  5'd0,  5'd0,  32'h00000000, 1'b0, 1'b0, 2'd0, 1'b0, 4'd0,  1'b0, 1'b1};
    dv[13] = '{32'h00000073, 1'b0, 1'b0, 5'd0,  5'd0,  5'd0,  32'h00000000, 1'b0, 1'b0, 2'd0, 1'b0, 4'd0,  1'b0, 1'b1};

    //          rs1           rs2           imm           s2    op     res
    av[0]  = '{32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 4'd3,  32'h00000001};
    av[1]  = '{32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 4'd4,  32'h00000000};
    av[2]  = '{32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 4'd0,  32'h00000000};
    av[3]  = '{32'h80000000, 32'h00000001, 32'h00000004, 1'b1, 4'd7,  32'hF8000000};
    av[4]  = '{32'h80000000, 32'h00000001, 32'h00000004, 1'b1, 4'd6,  32'h08000000};
    av[5]  = '{32'h00000000, 32'h00000001, 32'h00000000, 1'b0, 4'd1,  32'hFFFFFFFF};
    av[6]  = '{32'h00000001, 32'h00000021, 32'h00000000, 1'b0, 4'd2,  32'h00000002};
    av[7]  = '{32'hF0F0F0F0, 32'hFF00FF00, 32'h00000000, 1'b0, 4'd5,  32'h0FF00FF0};
    av[8]  = '{32'hF0F0F0F0, 32'hFF00FF00, 32'h00000000, 1'b0, 4'd8,  32'hFFF0FFF0};
    av[9]  = '{32'hF0F0F0F0, 32'hFF00FF00, 32'h00000000, 1'b0, 4'd9,  32'hF000F000};
    av[10] = '{32'h00000003, 32'h00000003, 32'h00000000, 1'b0, 4'd10, 32'h00000001};
    av[11] = '{32'h00000003, 32'h00000003, 32'h00000000, 1'b0, 4'd11, 32'h00000000};
    av[12] = '{32'h00000003, 32'h00000004, 32'h00000000, 1'b0, 4'd11, 32'h00000001};
    av[13] = '{32'hFFFFFFFF, 32'h00000000, 32'h00000000, 1'b0, 4'd12, 32'h00000001};
    av[14] = '{32'hFFFFFFFF, 32'h00000000, 32'h00000000, 1'b0, 4'd13, 32'h00000000};
    av[15] = '{32'hFFFFFFFF, 32'h00000000, 32'h00000000, 1'b0, 4'd14, 32'h00000000};
    av[16] = '{32'hFFFFFFFF, 32'h00000000, 32'h00000000, 1'b0, 4'd15, 32'h00000001};
    av[17] = '{32'h00000001, 32'h00000005, 32'h00000007, 1'b1, 4'd0,  32'h00000008};

    dif.inst_i = 32'h0; dif.alu_rs1_i = 32'h0; dif.alu_rs2_i = 32'h0; dif.alu_imm_i = 32'h0;
    dif.alu_sig_src2_i = 1'b0; dif.alu_sig_op_i = 4'd0;
    dif.wb_we_i = 1'b0; dif.wb_rd_i = 5'd0; dif.wb_sig_src_i = 2'd0;
    dif.wb_res_alu_i = 32'h0; dif.wb_res_mem_i = 32'h0; dif.wb_res_pc_i = 32'h0;

    #2;
    check("reset_gpr_any", {31'd0, |dif.gpr_o}, 32'd0);

    for (int i = 0; i < 14; i++) begin
      dif.inst_i = dv[i].inst;
      #1;
      check($sformatf("dec%0d_mem_we", i), {31'd0, dif.sig_mem_we_o}, {31'd0, dv[i].mem_we});
      check($sformatf("dec%0d_wb_we", i), {31'd0, dif.sig_wb_we_o}, {31'd0, dv[i].wb_we});
      check($sformatf("dec%0d_ebreak", i), {31'd0, dif.sig_ebreak_o}, {31'd0, dv[i].ebreak});
      check($sformatf("dec%0d_illegal", i), {31'd0, dif.sig_illegal_o}, {31'd0, dv[i].illegal});
      if (dv[i].full) begin
        check($sformatf("dec%0d_rd", i), {27'd0, dif.rd_o}, {27'd0, dv[i].rd});
        check($sformatf("dec%0d_rs1", i), {27'd0, dif.rs1_o}, {27'd0, dv[i].rs1});
        check($sformatf("dec%0d_rs2", i), {27'd0, dif.rs2_o}, {27'd0, dv[i].rs2});
        check($sformatf("dec%0d_imm", i), dif.imm_o, dv[i].imm);
      end
      if (dv[i].wb_we) begin
        check($sformatf("dec%0d_wb_src", i), {30'd0, dif.sig_wb_src_o}, {30'd0, dv[i].wb_src});
      end
      if (dv[i].alu) begin
        check($sformatf("dec%0d_op", i), {28'd0, dif.sig_alu_op_o}, {28'd0, dv[i].op});
        check($sformatf("dec%0d_src2", i), {31'd0, dif.sig_alu_src2_o}, {31'd0, dv[i].src2});
      end
    end

    for (int i = 0; i < 18; i++) begin
      dif.alu_rs1_i = av[i].rs1; dif.alu_rs2_i = av[i].rs2; dif.alu_imm_i = av[i].imm;
      dif.alu_sig_src2_i = av[i].src2; dif.alu_sig_op_i = av[i].op;
      #1;
      check($sformatf("alu%0d_op%0d", i, av[i].op), dif.res_o, av[i].res);
    end

    @(negedge clk);
    rst_n = 1'b1;

    // addi x1 write-back, then a pending write must not show before its edge
    wb_cycle(1'b1, 5'd1, 2'd0, 32'h5, 32'h0, 32'h0);
    check("wb_x1_alu", word(1), 32'h5);
    @(negedge clk);
    dif.wb_we_i = 1'b1; dif.wb_rd_i = 5'd1; dif.wb_sig_src_i = 2'd0; dif.wb_res_alu_i = 32'h99;
    #1;
    check("no_forward_x1", word(1), 32'h5);
    @(negedge clk);
    dif.wb_we_i = 1'b0;
    check("wb_x1_after_edge", word(1), 32'h99);

    wb_cycle(1'b1, 5'd1, 2'd2, 32'h0, 32'h0, 32'h100);
    check("wb_x1_pcnext", word(1), 32'h104);
    wb_cycle(1'b1, 5'd2, 2'd2, 32'h0, 32'h0, 32'hFFFFFFFC);
    check("wb_x2_pc_wrap", word(2), 32'h0);
    wb_cycle(1'b1, 5'd3, 2'd1, 32'h1, 32'hDEADBEEF, 32'h0);
    check("wb_x3_mem", word(3), 32'hDEADBEEF);
    wb_cycle(1'b1, 5'd4, 2'd3, 32'h55, 32'h66, 32'h77);
    check("wb_x4_src3", word(4), 32'h55);
    wb_cycle(1'b1, 5'd0, 2'd0, 32'h1234, 32'h0, 32'h0);
    check("wb_x0_ignored", word(0), 32'h0);
    wb_cycle(1'b0, 5'd6, 2'd0, 32'hABCD, 32'h0, 32'h0);
    check("wb_we_low_x6", word(6), 32'h0);
    wb_cycle(1'b1, 5'd5, 2'd0, 32'hAA, 32'h0, 32'h0);
    check("wb_x5", word(5), 32'hAA);

    // asynchronous reset in mid-cycle
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_x5", word(5), 32'h0);
    check("async_rst_x1", word(1), 32'h0);
    @(negedge clk);
    dif.wb_we_i = 1'b1; dif.wb_rd_i = 5'd7; dif.wb_sig_src_i = 2'd0; dif.wb_res_alu_i = 32'h77;
    @(negedge clk);
    check("write_in_reset_x7", word(7), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    dif.wb_we_i = 1'b0;
    check("first_write_after_rst_x7", word(7), 32'h77);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/decode_exec_writeback.md
Name: decode_exec_writeback

Overview:
- Combined decode / execute / write-back slice of the 5-stage RV32I pipeline core.
- Purely combinational instruction decoder (RV32I subset) and ALU, plus the clocked 31×32 general-purpose register file written at write-back.
- Sits between fetch/hazard logic and the pipeline stage registers. Operand values, including bypasses, are supplied externally.

Parameters:
- XLEN, 32, data path and register width.
- NREGS, 32, architectural register count; x0 is hard-wired to zero.

Ports:
- _clk  in  1  clock; register-file writes occur on the rising edge.
- _reset  in  1  asynchronous, active-low reset.
- _inst  in  32  instruction to decode.
- rd_ / rs1_ / rs2_  out  5 each  register fields, inst[11:7] / [19:15] / [24:20].
- imm_  out  32  sign-extended immediate.
- sig_mem_we_  out  1  store instruction.
- sig_wb_we_  out  1  instruction writes rd.
- sig_wb_src_  out  2  write-back source: 0=ALU, 1=MEM, 2=PCNEXT.
- sig_alu_src2_  out  1  ALU operand 2 source: 0=REG, 1=IMM.
- sig_alu_op_  out  4  ALU operation code (encoding below).
- sig_ebreak_  out  1  instruction is EBREAK (0x00100073).
- sig_illegal_  out  1  opcode not supported.
- _rs1, _rs2  in  32 each  ALU operand values (already bypassed).
- _imm  in  32  immediate for the ALU.
- _sig_src2  in  1  operand 2 select.
- _sig_op  in  4  ALU operation.
- res_  out  32  ALU result.
- _we  in  1  write-back enable.
- _rd  in  5  write-back destination.
- _res_alu, _res_mem, _res_pc  in  32 each  candidate write-back values.
- _sig_src  in  2  write-back source select.
- gpr_  out  1024  flattened register file; word i is bits [32i+31:32i]; word 0 is always 0.

Behaviour:
- Decoder is combinational with no state.
- Decoder immediate formats:
  - I-type: inst[31:20] sign-extended.
  - S-type: {inst[31:25], inst[11:7]}.
  - B-type: {inst[31], inst[7], inst[30:25], inst[11:8], 0}.
  - U-type: {inst[31:12], 12'b0}.
  - J-type: {inst[31], inst[19:12], inst[20], inst[30:21], 0}.
- ALU op encoding:
  - 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND.
  - Compares: 10 EQ, 11 NE, 12 LT, 13 GE, 14 LTU, 15 GEU.
- Decode by opcode:
  - OP (0110011): ALU op from funct3 and inst[30]; src2=REG; wb_we=1; wb_src=ALU.
  - OP-IMM (0010011): src2=IMM; SRAI selected by inst[30]; no SUBI; wb=ALU.
  - LUI (0110111): rs1_ forced to 0; ADD with IMM; wb=ALU.
  - LOAD/LW (0000011): ADD with IMM; wb_we=1; wb_src=MEM.
  - STORE/SW (0100011): ADD with S-immediate; mem_we=1; wb_we=0.
  - BRANCH (1100011): compare op from funct3 (BEQ→EQ, BNE→NE, BLT→LT, BGE→GE, BLTU→LTU, BGEU→GEU); src2=REG; wb_we=0.
  - JAL (1101111): J-immediate; wb_we=1; wb_src=PCNEXT.
  - JALR (1100111): ADD rs1+imm; wb_we=1; wb_src=PCNEXT.
- EBREAK: sig_ebreak_=1; all write enables 0.
- Any other encoding:
  - sig_illegal_=1; wb_we, mem_we and ebreak are all 0; remaining outputs don't-care but stable.
- ALU (combinational):
  - Operand 2 = _sig_src2 ? _imm : _rs2.
  - Shifts use operand2[4:0].
  - SLT/LT/GE are signed; the U variants are unsigned.
  - Compare ops return 32'h1 if true, else 32'h0. Bit 0 is the branch-taken flag.
  - Add/sub wrap modulo 2^32.
- Write-back:
  - Data = ALU→_res_alu, MEM→_res_mem, PCNEXT→_res_pc+4 (wrapping). _sig_src=3 writes _res_alu.
  - On rising _clk with _we=1 and _rd≠0, x[_rd] is updated; the new value appears on gpr_ after the edge.
  - Writes to x0 are ignored; gpr_ word 0 stays 0.
- Reset:
  - _reset low asynchronously clears x1..x31 to 0, immediately and regardless of clock.
  - Writes are blocked while reset is low.
  - The first write is accepted on the first rising edge after reset deasserts.
- No read-during-write forwarding inside the block: gpr_ shows the pre-edge value until the edge.

Test Plan:
- Decode 0x00500093 (addi x1,x0,5) → rd_=1, rs1_=0, imm_=5, op=ADD, src2=IMM, wb_we=1, wb_src=ALU. Then _we=1, _rd=1, src=ALU, _res_alu=5 at an edge → gpr_ word1=5.
- ALU with _rs1=0xFFFFFFFF, _rs2=1:
  - SLT → 1; SLTU → 0; ADD → 0; SRA with operand2=4 on 0x80000000 → 0xF8000000.
- Decode BNE 0xFE209EE3 → op=NE, imm_=0xFFFFFFFC, wb_we=0. ALU NE with 3,3 → 0; with 3,4 → 1.
- Decode JAL 0x008000EF → wb_src=PCNEXT, imm_=8. Write-back with _res_pc=0x100 → x1=0x104.
- Write to x0 with data 0x1234 → word0 stays 0. Decode SW 0x00112223 → mem_we=1, wb_we=0, imm_=4.
- Load x5=0xAA, then assert _reset low mid-cycle → x5 reads 0 without a clock edge. A write while reset is low has no effect. Decode 0x00100073 → ebreak=1. Decode 0x0000000B → illegal=1.
